serial_to_parallel_aligned: RTL
===============================

Name: serial_to_parallel_aligned

Overview:
- Parametrised successor to the fixed 8-bit serial-to-parallel converter.
- Deserialises a 1-bit stream into WIDTH-bit words and finds word alignment by hunting for the COM symbol at any bit offset.
- Declares the link ACTIVE after LOCK_COUNT consecutive aligned COM words, then presents every word and flags real data (not COM, not IDL) with a one-cycle valid pulse.
- Sits between the serial line receiver and the byte-level receive logic.

Parameters:
- WIDTH, 8: word width in bits, >= 2.
- COM, 8'hBC: alignment symbol, WIDTH bits.
- IDL, 8'h7C: idle symbol, WIDTH bits; never flagged valid.
- LOCK_COUNT, 4: consecutive aligned COM words needed to enter ACTIVE, 1..15.
- MSB_FIRST, 1: 1 = first received bit is word bit WIDTH-1; 0 = first received bit is word bit 0.

Ports:
- CLK  input  1  sole clock, all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- DATA_IN  input  1  serial bit, sampled every rising edge.
- DATA_OUT  output  WIDTH  last complete aligned word, held between word boundaries.
- VALID_OUT  output  1  one-cycle pulse when DATA_OUT has just updated with a word that is neither COM nor IDL.
- ACTIVE  output  1  high while locked.
- ALIGNED  output  1  high in SYNC or ACTIVE (boundary known).

Behaviour:
- Reset values (RESET low, asynchronous): state=HUNT, shift register=0, bit counter=0, COM counter=0, DATA_OUT=0, VALID_OUT=0, ACTIVE=0, ALIGNED=0.
- Candidate word: the WIDTH-1 stored bits plus the current DATA_IN.
  - MSB_FIRST=1: cand={sr[WIDTH-2:0],DATA_IN}, shift left.
  - MSB_FIRST=0: cand={DATA_IN,sr[WIDTH-1:1]}, shift right.
  - The shift register shifts every cycle in every state.
- HUNT:
  - Each cycle, if cand==COM: go to SYNC, COM counter=1, bit counter=0.
  - If additionally LOCK_COUNT==1: go directly to ACTIVE instead.
- Bit counter: increments 0..WIDTH-1 and wraps. A boundary is the cycle the counter equals WIDTH-1, i.e. the WIDTH-th bit after the previous boundary.
- SYNC, at each boundary:
  - cand==COM: COM counter+1. If it reaches LOCK_COUNT, go to ACTIVE on that same edge.
  - cand!=COM: return to HUNT, COM counter=0. The same cycle does not re-evaluate the hunt.
  - Non-boundary cycles: no decision.
- ACTIVE:
  - At each boundary: DATA_OUT<=cand; VALID_OUT<=1 if cand!=COM and cand!=IDL, else 0.
  - VALID_OUT=0 on all other cycles.
  - ACTIVE stays high until reset; COM words in ACTIVE only update DATA_OUT.
- Latency: the word completed by the bit sampled at edge N appears on DATA_OUT/VALID_OUT immediately after edge N.
- Lock timing: ACTIVE rises after the edge sampling the last bit of the LOCK_COUNT-th COM. That COM word itself is not written to DATA_OUT.
- ALIGNED = (state != HUNT), registered with the state.
- Bit counter width: clog2(WIDTH). COM counter width: 4 bits, saturating at LOCK_COUNT.
- Reset mid-operation (any state, any bit position): immediate return to reset values; alignment is lost and the hunt restarts.
- COM/IDL aliasing: when COM==IDL the COM comparison takes precedence; the word is never valid.

Test Plan:
- Clean lock (WIDTH=8, MSB_FIRST=1): 4×0xBC MSB-first after reset.
  - ALIGNED rises after bit 8.
  - ACTIVE rises after bit 32.
  - DATA_OUT stays 0x00; VALID_OUT never pulses.
- Data/idle filtering: after lock send 0x7C, 0xA5, 0xBC, 0x0C.
  - DATA_OUT steps 7C, A5, BC, 0C, each update 8 cycles apart.
  - VALID_OUT pulses exactly once each for A5 and 0C.
- Arbitrary offset: 3 junk bits 1,0,1 then 4×0xBC then 0x55.
  - Lock still occurs at the last BC bit.
  - DATA_OUT=0x55 with a VALID_OUT pulse.
- Broken lock sequence: BC, BC, 0x55, BC, BC, BC, BC.
  - Return to HUNT at the 0x55 boundary (ALIGNED=0).
  - Re-align on the next BC; ACTIVE only after the 4th BC following 0x55.
- Reset mid-word: drive RESET low for 1 cycle, 3 bits into a data word while ACTIVE.
  - All outputs are 0 asynchronously.
  - A fresh 4×BC sequence is required to re-lock.
- Parameter variant (WIDTH=10, COM=10'h17C, LOCK_COUNT=1, MSB_FIRST=0): one COM sent LSB-first.
  - ACTIVE after its 10th bit.
  - Next word 0x2AA gives DATA_OUT=0x2AA with a VALID_OUT pulse.

Source files
------------

// File: rtl/serial_to_parallel_aligned.sv
// Serial-to-parallel deserialiser with COM-symbol word alignment and lock detection.
// Presents aligned words once locked and pulses VALID_OUT for real data words.
module serial_to_parallel_aligned #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  COM        = WIDTH'(8'hBC),
  parameter logic [WIDTH-1:0]  IDL        = WIDTH'(8'h7C),
  parameter int unsigned       LOCK_COUNT = 4,
  parameter bit                MSB_FIRST  = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             ACTIVE,
  output logic             ALIGNED
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]        LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic             aligned_q, aligned_d;

  logic [WIDTH-1:0] cand;
  logic             boundary;
  logic             is_com;
  logic             is_idl;

  // Candidate word: stored bits plus the bit arriving this cycle.
  always_comb begin
    if (MSB_FIRST) begin
      cand = {sr_q[WIDTH-2:0], DATA_IN};
    end else begin
      cand = {DATA_IN, sr_q[WIDTH-1:1]};
    end
  end

  assign boundary = (bit_cnt_q == LAST_BIT);
  assign is_com   = (cand == COM);
  assign is_idl   = (cand == IDL);

  // Next-state and output decisions.
  always_comb begin
    state_d   = state_q;
    sr_d      = cand;
    bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
    com_cnt_d = com_cnt_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (is_com) begin
          com_cnt_d = 4'd1;
          bit_cnt_d = '0;
          state_d   = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (boundary) begin
          if (is_com) begin
            if (com_cnt_q + 4'd1 >= LOCK_CNT) begin
              com_cnt_d = LOCK_CNT;
              state_d   = ST_ACTIVE;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          dout_d  = cand;
          // COM wins over IDL when the two symbols alias.
          valid_d = !is_com && !is_idl;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    active_d  = (state_d == ST_ACTIVE);
    aligned_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= 4'd0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      aligned_q <= aligned_d;
    end
  end

  assign DATA_OUT  = dout_q;
  assign VALID_OUT = valid_q;
  assign ACTIVE    = active_q;
  assign ALIGNED   = aligned_q;

endmodule
